reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/reorder_buffer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer_pkg
// Brief    : Shared constants and pointer helper for the reorder buffer.
// Revision : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

    localparam int ROB_SIZE   = 16;   // includes reserved tag 0
    localparam int ROB_WIDTH  = 4;
    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;

    localparam logic [ROB_WIDTH-1:0] ZERO_ROB  = 4'd0;  // "no producer"
    localparam logic [ROB_WIDTH-1:0] FIRST_ROB = 4'd1;
    localparam logic [ROB_WIDTH-1:0] LAST_ROB  = 4'd15;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Pointers cycle 1..15 and skip the reserved tag 0.
    function automatic logic [ROB_WIDTH-1:0] rob_next(input logic [ROB_WIDTH-1:0] ptr);
        return (ptr == LAST_ROB) ? FIRST_ROB : ptr + FIRST_ROB;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reorder_buffer
// Brief    : 15-slot in-order-commit reorder buffer with CDB capture and
//            operand forwarding. Optional macro ROB_FLUSH_EN adds a flush input.
// Revision : 1.0 - initial release
// ============================================================================
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
`ifdef ROB_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  alloc_req,
    input  logic [REG_WIDTH-1:0]  alloc_dest_reg,
    output logic                  alloc_ready,
    output logic [ROB_WIDTH-1:0]  alloc_tag,
    input  logic                  cdb_valid,
    input  logic [ROB_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_value,
    input  logic [ROB_WIDTH-1:0]  query_tag1,
    input  logic [ROB_WIDTH-1:0]  query_tag2,
    output logic                  query_ready1,
    output logic                  query_ready2,
    output logic [DATA_WIDTH-1:0] query_value1,
    output logic [DATA_WIDTH-1:0] query_value2,
    output logic [REG_WIDTH-1:0]  out_reg_index,
    output logic [ROB_WIDTH-1:0]  out_entry_tag,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic                  empty
);

    logic [ROB_SIZE-1:0]   busy_q, busy_d;
    logic [ROB_SIZE-1:0]   ready_q, ready_d;
    logic [REG_WIDTH-1:0]  dest_q  [ROB_SIZE];
    logic [REG_WIDTH-1:0]  dest_d  [ROB_SIZE];
    logic [DATA_WIDTH-1:0] value_q [ROB_SIZE];
    logic [DATA_WIDTH-1:0] value_d [ROB_SIZE];
    logic [ROB_WIDTH-1:0]  head_q, head_d;
    logic [ROB_WIDTH-1:0]  tail_q, tail_d;
    logic [ROB_WIDTH-1:0]  count_q, count_d;
    logic [REG_WIDTH-1:0]  out_reg_index_q, out_reg_index_d;
    logic [ROB_WIDTH-1:0]  out_entry_tag_q, out_entry_tag_d;
    logic [DATA_WIDTH-1:0] out_value_q, out_value_d;

    logic w_do_alloc;
    logic w_do_commit;
    logic w_cdb_hit;

    // Status outputs and the three per-cycle decisions, all from pre-edge state.
    always_comb begin
        alloc_ready   = (count_q != LAST_ROB);
        alloc_tag     = tail_q;
        empty         = (count_q == ZERO_ROB);
        w_do_alloc    = ena && alloc_req && alloc_ready;
        w_do_commit   = ena && busy_q[head_q] && ready_q[head_q];
        w_cdb_hit     = ena && cdb_valid && (cdb_tag != ZERO_ROB) && busy_q[cdb_tag];
        out_reg_index = out_reg_index_q;
        out_entry_tag = out_entry_tag_q;
        out_value     = out_value_q;
    end

    // Operand forwarding: a matching CDB broadcast beats the stored entry.
    always_comb begin
        query_ready1 = FALSE;
        query_value1 = '0;
        query_ready2 = FALSE;
        query_value2 = '0;
        if (query_tag1 != ZERO_ROB) begin
            if (cdb_valid && (cdb_tag == query_tag1)) begin
                query_ready1 = TRUE;
                query_value1 = cdb_value;
            end else begin
                query_ready1 = ready_q[query_tag1];
                query_value1 = value_q[query_tag1];
            end
        end
        if (query_tag2 != ZERO_ROB) begin
            if (cdb_valid && (cdb_tag == query_tag2)) begin
                query_ready2 = TRUE;
                query_value2 = cdb_value;
            end else begin
                query_ready2 = ready_q[query_tag2];
                query_value2 = value_q[query_tag2];
            end
        end
    end

    // Next-state: CDB capture, then head commit, then tail allocation.
    always_comb begin
        busy_d          = busy_q;
        ready_d         = ready_q;
        dest_d          = dest_q;
        value_d         = value_q;
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        out_reg_index_d = '0;
        out_entry_tag_d = ZERO_ROB;
        out_value_d     = out_value_q;

        if (w_cdb_hit) begin
            ready_d[cdb_tag] = TRUE;
            value_d[cdb_tag] = cdb_value;
        end
        // Commit payload comes from pre-edge contents, so a same-cycle CDB
        // write to the head cannot commit until the following edge.
        if (w_do_commit) begin
            out_reg_index_d = dest_q[head_q];
            out_entry_tag_d = head_q;
            out_value_d     = value_q[head_q];
            busy_d[head_q]  = FALSE;
            ready_d[head_q] = FALSE;
            head_d          = rob_next(head_q);
        end
        // Allocation only happens when not full, so tail never equals a
        // committing head here.
        if (w_do_alloc) begin
            busy_d[tail_q]  = TRUE;
            ready_d[tail_q] = FALSE;
            dest_d[tail_q]  = alloc_dest_reg;
            tail_d          = rob_next(tail_q);
        end
        case ({w_do_alloc, w_do_commit})
            2'b10:   count_d = count_q + FIRST_ROB;
            2'b01:   count_d = count_q - FIRST_ROB;
            default: count_d = count_q;
        endcase
`ifdef ROB_FLUSH_EN
        // Flush overrides everything above and ignores ena.
        if (flush) begin
            busy_d          = '0;
            ready_d         = '0;
            head_d          = FIRST_ROB;
            tail_d          = FIRST_ROB;
            count_d         = ZERO_ROB;
            out_reg_index_d = '0;
            out_entry_tag_d = ZERO_ROB;
            out_value_d     = '0;
        end
`endif
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q          <= '0;
            ready_q         <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                dest_q[i]  <= '0;
                value_q[i] <= '0;
            end
            head_q          <= FIRST_ROB;
            tail_q          <= FIRST_ROB;
            count_q         <= ZERO_ROB;
            out_reg_index_q <= '0;
            out_entry_tag_q <= ZERO_ROB;
            out_value_q     <= '0;
        end else begin
            busy_q          <= busy_d;
            ready_q         <= ready_d;
            dest_q          <= dest_d;
            value_q         <= value_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            out_reg_index_q <= out_reg_index_d;
            out_entry_tag_q <= out_entry_tag_d;
            out_value_q     <= out_value_d;
        end
    end

endmodule
`default_nettype wire
